// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes, FSM state encoding and default JEDEC ID
// shared by the SPI flash responder.
package spi_flash_pkg;
  localparam logic [7:0]  OP_READ          = 8'h03;
  localparam logic [7:0]  OP_RDSR          = 8'h05;
  localparam logic [7:0]  OP_RDID          = 8'h9F;
  localparam logic [23:0] DEFAULT_JEDEC_ID = 24'hEF4016;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DATA, STATUS, JEDEC, IGNORE
  } state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: SYNC_STAGES-deep synchroniser for SCK/CS/MOSI, with rise/fall
// detection on the synchronised SCK. o_valid marks the chain as flushed after reset.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sck,
  input  logic i_cs,
  input  logic i_mosi,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_cs,
  output logic o_mosi,
  output logic o_valid
);
  logic [SYNC_STAGES-1:0] r_sck;
  logic [SYNC_STAGES-1:0] r_cs;
  logic [SYNC_STAGES-1:0] r_mosi;
  logic [SYNC_STAGES-1:0] r_vld;
  logic                   r_sck_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck      <= '0;
      r_cs       <= '1;
      r_mosi     <= '0;
      r_vld      <= '0;
      r_sck_prev <= 1'b0;
    end else begin
      r_sck      <= SYNC_STAGES'({r_sck, i_sck});
      r_cs       <= SYNC_STAGES'({r_cs, i_cs});
      r_mosi     <= SYNC_STAGES'({r_mosi, i_mosi});
      r_vld      <= SYNC_STAGES'({r_vld, 1'b1});
      r_sck_prev <= r_sck[SYNC_STAGES-1];
    end
  end

  assign o_sck_rise = r_sck[SYNC_STAGES-1] & ~r_sck_prev;
  assign o_sck_fall = ~r_sck[SYNC_STAGES-1] & r_sck_prev;
  assign o_cs       = r_cs[SYNC_STAGES-1];
  assign o_mosi     = r_mosi[SYNC_STAGES-1];
  assign o_valid    = r_vld[SYNC_STAGES-1];
endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 flash responder (READ 0x03, RDSR 0x05) backed by a byte store.
// Define SPI_FLASH_RESPONDER_JEDEC_EN to enable the 0x9F JEDEC ID response.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter logic [23:0] JEDEC_ID    = DEFAULT_JEDEC_ID,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_SPI_CLK,
  input  logic        i_SPI_CS,
  input  logic        i_SPI_MOSI,
  output logic        o_SPI_MISO,
  output logic        o_MISO_OE,
  output logic        o_RD_REQ,
  output logic [23:0] o_RD_ADDR,
  input  logic [7:0]  i_RD_DATA,
  input  logic        i_RD_VALID,
  output logic        o_UNDERRUN,
  output logic        o_BUSY
);
  logic w_sck_rise, w_sck_fall, w_cs, w_mosi, w_sync_vld;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .i_sck     (i_SPI_CLK),
    .i_cs      (i_SPI_CS),
    .i_mosi    (i_SPI_MOSI),
    .o_sck_rise(w_sck_rise),
    .o_sck_fall(w_sck_fall),
    .o_cs      (w_cs),
    .o_mosi    (w_mosi),
    .o_valid   (w_sync_vld)
  );

  state_t      r_state;
  logic [4:0]  r_bit_cnt;
  logic [22:0] r_shift;
  logic [7:0]  r_tx;
  logic        r_cs_prev;
  logic        r_pend;
  logic        r_have;
  logic [7:0]  r_buf;
  logic        r_miso, r_oe, r_rd_req, r_underrun, r_busy;
  logic [23:0] r_rd_addr;
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
  logic [1:0]  r_id_idx;
`else
  logic        w_unused_jedec;
  assign w_unused_jedec = ^{JEDEC_ID, OP_RDID};
`endif

  logic       w_cs_fall, w_cap, w_byte_ok;
  logic [7:0] w_data_byte, w_resp_byte, w_opcode;

  always_comb begin
    // r_cs_prev only tracks once the synchroniser is flushed, so a CS held low
    // through reset is not mistaken for a fresh falling edge.
    w_cs_fall   = w_sync_vld && r_cs_prev && !w_cs;
    w_cap       = i_RD_VALID && r_pend;
    w_byte_ok   = r_have || w_cap;
    w_data_byte = r_have ? r_buf : (w_cap ? i_RD_DATA : 8'hFF);
    w_opcode    = {r_shift[6:0], w_mosi};
    w_resp_byte = 8'h00;
    case (r_state)
      DATA: w_resp_byte = w_data_byte;
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
      JEDEC: begin
        case (r_id_idx)
          2'd0:    w_resp_byte = JEDEC_ID[23:16];
          2'd1:    w_resp_byte = JEDEC_ID[15:8];
          2'd2:    w_resp_byte = JEDEC_ID[7:0];
          default: w_resp_byte = 8'hFF;
        endcase
      end
`endif
      default: w_resp_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= '0;
      r_cs_prev  <= 1'b0;
      r_pend     <= 1'b0;
      r_have     <= 1'b0;
      r_buf      <= '0;
      r_miso     <= 1'b0;
      r_oe       <= 1'b0;
      r_rd_req   <= 1'b0;
      r_rd_addr  <= '0;
      r_underrun <= 1'b0;
      r_busy     <= 1'b0;
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
      r_id_idx   <= '0;
`endif
    end else begin
      r_rd_req   <= 1'b0;
      r_underrun <= 1'b0;
      if (w_sync_vld) r_cs_prev <= w_cs;
      if (w_cap) begin
        r_buf  <= i_RD_DATA;
        r_have <= 1'b1;
        r_pend <= 1'b0;
      end
      if (w_cs) begin
        r_state <= IDLE;
        r_oe    <= 1'b0;
        r_busy  <= 1'b0;
        r_miso  <= 1'b0;
        r_pend  <= 1'b0;
        r_have  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (w_cs_fall) begin
            r_state   <= CMD;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_busy    <= 1'b1;
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
            r_id_idx  <= '0;
`endif
          end
          CMD: if (w_sck_rise) begin
            r_shift   <= {r_shift[21:0], w_mosi};
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd7) begin
              r_bit_cnt <= '0;
              case (w_opcode)
                OP_READ: r_state <= ADDR;
                OP_RDSR: r_state <= STATUS;
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
                OP_RDID: r_state <= JEDEC;
`endif
                default: r_state <= IGNORE;
              endcase
            end
          end
          ADDR: if (w_sck_rise) begin
            r_shift   <= {r_shift[21:0], w_mosi};
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd23) begin
              r_rd_addr <= {r_shift, w_mosi};
              r_rd_req  <= 1'b1;
              r_pend    <= 1'b1;
              r_have    <= 1'b0;
              r_bit_cnt <= '0;
              r_state   <= DATA;
            end
          end
          DATA, STATUS, JEDEC: if (w_sck_fall) begin
            if (r_bit_cnt[2:0] == 3'd0) begin
              r_miso <= w_resp_byte[7];
              r_tx   <= {w_resp_byte[6:0], 1'b0};
              r_oe   <= 1'b1;
              // A new prefetch supersedes any request still outstanding.
              if (r_state == DATA) begin
                r_rd_addr  <= r_rd_addr + 24'd1;
                r_rd_req   <= 1'b1;
                r_pend     <= 1'b1;
                r_have     <= 1'b0;
                r_underrun <= !w_byte_ok;
              end
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
              if (r_id_idx != 2'd3) r_id_idx <= r_id_idx + 2'd1;
`endif
            end else begin
              r_miso <= r_tx[7];
              r_tx   <= {r_tx[6:0], 1'b0};
            end
            r_bit_cnt <= {2'b00, r_bit_cnt[2:0] + 3'd1};
          end
          IGNORE: ;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_SPI_MISO = r_miso;
  assign o_MISO_OE  = r_oe;
  assign o_RD_REQ   = r_rd_req;
  assign o_RD_ADDR  = r_rd_addr;
  assign o_UNDERRUN = r_underrun;
  assign o_BUSY     = r_busy;
endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: stimulus queues expected read
// addresses, MISO bytes and underruns; monitors pop and compare as the DUT emits them.
module tb_spi_flash_responder;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_SPI_CLK, i_SPI_CS, i_SPI_MOSI;
  logic        o_SPI_MISO, o_MISO_OE, o_RD_REQ, o_UNDERRUN, o_BUSY;
  logic [23:0] o_RD_ADDR;
  logic [7:0]  i_RD_DATA;
  logic        i_RD_VALID;

  spi_flash_responder #(.JEDEC_ID(24'hEF4016), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_SPI_CLK (i_SPI_CLK),
    .i_SPI_CS  (i_SPI_CS),
    .i_SPI_MOSI(i_SPI_MOSI),
    .o_SPI_MISO(o_SPI_MISO),
    .o_MISO_OE (o_MISO_OE),
    .o_RD_REQ  (o_RD_REQ),
    .o_RD_ADDR (o_RD_ADDR),
    .i_RD_DATA (i_RD_DATA),
    .i_RD_VALID(i_RD_VALID),
    .o_UNDERRUN(o_UNDERRUN),
    .o_BUSY    (o_BUSY)
  );

  initial forever #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [23:0] exp_req[$];
  logic [23:0] exp_und[$];
  logic [7:0]  exp_miso[$];
  int oe_cnt = 0;
  int oe_base;
  logic        withhold_en;
  logic [23:0] withhold_addr;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Backing store: data = addr[7:0] ^ 8'hA5, returned 3 clks after the request.
  initial begin
    int lat_cnt;
    logic [23:0] st_addr;
    lat_cnt = 0;
    st_addr = '0;
    i_RD_VALID = 1'b0;
    i_RD_DATA  = 8'h00;
    forever begin
      @(negedge clk);
      i_RD_VALID = 1'b0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          i_RD_VALID = 1'b1;
          i_RD_DATA  = st_addr[7:0] ^ 8'hA5;
        end
      end
      if (o_RD_REQ && !(withhold_en && o_RD_ADDR == withhold_addr)) begin
        st_addr = o_RD_ADDR;
        lat_cnt = 3;
      end
    end
  end

  // Monitor: read requests, underrun pulses, MISO_OE activity.
  always @(negedge clk) begin
    if (o_MISO_OE) oe_cnt++;
    if (o_RD_REQ) begin
      if (exp_req.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL rd_req unexpected: got addr %h, expected none", o_RD_ADDR);
      end else chk("rd_addr", o_RD_ADDR, exp_req.pop_front());
    end
    if (o_UNDERRUN) begin
      if (exp_und.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL underrun unexpected: got pulse at addr %h, expected none", o_RD_ADDR);
      end else chk("underrun_addr", o_RD_ADDR, exp_und.pop_front());
    end
  end

  // Monitor: MISO bytes sampled on SCK rising while the DUT drives.
  logic [7:0] rx_byte = 8'h00;
  int rx_cnt = 0;
  always @(posedge i_SPI_CLK) begin
    if (!o_MISO_OE) rx_cnt = 0;
    else begin
      rx_byte = {rx_byte[6:0], o_SPI_MISO};
      rx_cnt++;
      if (rx_cnt == 8) begin
        rx_cnt = 0;
        if (exp_miso.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL miso unexpected: got byte %h, expected none", rx_byte);
        end else chk("miso_byte", 24'(rx_byte), 24'(exp_miso.pop_front()));
      end
    end
  end

  task automatic spi_bit(input logic b);
    i_SPI_MOSI = b;
    clk_wait(HALF);
    i_SPI_CLK = 1'b1;
    clk_wait(HALF);
    i_SPI_CLK = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic spi_begin();
    i_SPI_CS = 1'b0;
    clk_wait(HALF);
  endtask

  task automatic spi_end();
    clk_wait(HALF);
    i_SPI_CS = 1'b1;
    clk_wait(2 * HALF);
  endtask

  task automatic read_xfer(input logic [23:0] a, input int n);
    spi_begin();
    spi_byte(8'h03);
    for (int i = 23; i >= 0; i--) spi_bit(a[i]);
    repeat (n) spi_byte(8'h00);
    spi_end();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_miso"},  24'(o_SPI_MISO), 24'h0);
    chk({tag, "_oe"},    24'(o_MISO_OE),  24'h0);
    chk({tag, "_req"},   24'(o_RD_REQ),   24'h0);
    chk({tag, "_und"},   24'(o_UNDERRUN), 24'h0);
    chk({tag, "_busy"},  24'(o_BUSY),     24'h0);
    chk({tag, "_addr"},  o_RD_ADDR,       24'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; i_SPI_CS = 1'b1; i_SPI_CLK = 1'b0; i_SPI_MOSI = 1'b0;
    withhold_en = 1'b0; withhold_addr = '0;
    clk_wait(3);
    chk_all_zero("reset");
    reset = 1'b0;
    clk_wait(4);

    // READ 0x00F000, one byte; prefetches continue to F001/F002.
    exp_req.push_back(24'h00F000); exp_req.push_back(24'h00F001); exp_req.push_back(24'h00F002);
    exp_miso.push_back(8'hA5);
    read_xfer(24'h00F000, 1);

    // READ across the address wrap.
    exp_req.push_back(24'hFFFFFF); exp_req.push_back(24'h000000); exp_req.push_back(24'h000001);
    exp_req.push_back(24'h000002); exp_req.push_back(24'h000003);
    exp_miso.push_back(8'h5A); exp_miso.push_back(8'hA5); exp_miso.push_back(8'hA4);
    read_xfer(24'hFFFFFF, 3);

    // Withheld data: byte reads FF, one underrun while the address still advances.
    withhold_en = 1'b1; withhold_addr = 24'h00F000;
    exp_req.push_back(24'h00F000); exp_req.push_back(24'h00F001); exp_req.push_back(24'h00F002);
    exp_und.push_back(24'h00F001);
    exp_miso.push_back(8'hFF);
    read_xfer(24'h00F000, 1);
    withhold_en = 1'b0;

    // JEDEC ID.
    oe_base = oe_cnt;
`ifdef SPI_FLASH_RESPONDER_JEDEC_EN
    exp_miso.push_back(8'hEF); exp_miso.push_back(8'h40);
    exp_miso.push_back(8'h16); exp_miso.push_back(8'hFF);
`endif
    spi_begin();
    spi_byte(8'h9F);
    repeat (4) spi_byte(8'h00);
    spi_end();
`ifndef SPI_FLASH_RESPONDER_JEDEC_EN
    chk("rdid_oe_cycles", 24'(oe_cnt - oe_base), 24'h0);
`endif

    // CS abort after 12 address bits, then a status read.
    oe_base = oe_cnt;
    spi_begin();
    spi_byte(8'h03);
    for (int i = 11; i >= 0; i--) spi_bit(i[0]);
    clk_wait(4);
    chk("abort_busy_before", 24'(o_BUSY), 24'h1);
    i_SPI_CS = 1'b1;
    clk_wait(4);
    chk("abort_busy_after", 24'(o_BUSY), 24'h0);
    chk("abort_oe_cycles", 24'(oe_cnt - oe_base), 24'h0);
    clk_wait(2 * HALF);
    exp_miso.push_back(8'h00); exp_miso.push_back(8'h00);
    spi_begin();
    spi_byte(8'h05);
    repeat (2) spi_byte(8'h00);
    spi_end();

    // Reset mid-DATA with CS still low; the responder waits for a fresh CS fall.
    exp_req.push_back(24'h000010); exp_req.push_back(24'h000011);
    spi_begin();
    spi_byte(8'h03);
    for (int i = 23; i >= 0; i--) spi_bit(i == 4);
    repeat (4) spi_bit(1'b1);
    reset = 1'b1;
    clk_wait(1);
    chk_all_zero("midreset");
    reset = 1'b0;
    oe_base = oe_cnt;
    spi_byte(8'h05);
    chk("postreset_busy", 24'(o_BUSY), 24'h0);
    chk("postreset_oe_cycles", 24'(oe_cnt - oe_base), 24'h0);
    spi_end();
    exp_req.push_back(24'h00F000); exp_req.push_back(24'h00F001); exp_req.push_back(24'h00F002);
    exp_miso.push_back(8'hA5);
    read_xfer(24'h00F000, 1);

    clk_wait(20);
    chk("leftover_req", 24'(exp_req.size()), 24'h0);
    chk("leftover_und", 24'(exp_und.size()), 24'h0);
    chk("leftover_miso", 24'(exp_miso.size()), 24'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 The parameter list SHALL be: JEDEC_ID, 24'hEF4016, 3-byte ID returned for opcode 0x9F.
REQ-002 The parameter list SHALL be: SYNC_STAGES, 2, synchroniser depth on SCK/CS/MOSI.
REQ-003 The port list SHALL start with: clk  input  1  system clock; one clock domain; clk SHALL be >= 8x max SCK.
REQ-004 The port list SHALL include: reset  input  1  synchronous, active-high reset.
REQ-005 The port list SHALL include: i_SPI_CLK  input  1  SPI clock from the initiator, mode 0.
REQ-006 The port list SHALL include: i_SPI_CS  input  1  chip select, active low.
REQ-007 The port list SHALL include: i_SPI_MOSI  input  1  serial data from the initiator.
REQ-008 The port list SHALL include: o_SPI_MISO  output  1  serial data to the initiator.
REQ-009 The port list SHALL include: o_MISO_OE  output  1  MISO drive enable, high only during response phases.
REQ-010 The port list SHALL include: o_RD_REQ  output  1  single-clk backing-store read strobe.
REQ-011 The port list SHALL include: o_RD_ADDR  output  24  backing-store byte address.
REQ-012 The port list SHALL include: i_RD_DATA  input  8  backing-store byte.
REQ-013 The port list SHALL include: i_RD_VALID  input  1  i_RD_DATA valid; one-clk pulse.
REQ-014 The port list SHALL include: o_UNDERRUN  output  1  one-clk pulse when data arrived too late.
REQ-015 The port list SHALL include: o_BUSY  output  1  high while CS is low after synchronisation.

Function
REQ-016 SCK, CS and MOSI SHALL pass through SYNC_STAGES flops; edges SHALL be detected on the synchronised SCK.
REQ-017 MOSI SHALL be sampled on SCK rising; MISO SHALL change on SCK falling; MSB first.
REQ-018 FSM states SHALL be IDLE, CMD, ADDR, DATA, STATUS, JEDEC, IGNORE.
REQ-019 IDLE -> CMD SHALL occur on synchronised CS falling; bit counter cleared.
REQ-020 After the 8th bit, CMD SHALL dispatch: 0x03 -> ADDR; 0x05 -> STATUS; 0x9F -> JEDEC; other -> IGNORE.
REQ-021 ADDR SHALL shift 24 bits; on the 24th rising edge, o_RD_ADDR SHALL load the address and o_RD_REQ SHALL pulse the next clk.
REQ-022 DATA SHALL load the fetched byte on each byte-boundary falling edge, then increment o_RD_ADDR and pulse o_RD_REQ (prefetch).
REQ-023 Address increment SHALL wrap 24'hFFFFFF -> 24'h000000.
REQ-024 If i_RD_VALID has not arrived by a byte-load falling edge, the byte SHALL be 8'hFF, o_UNDERRUN SHALL pulse, and the address SHALL still advance.
REQ-025 An i_RD_VALID arriving with no request outstanding SHALL be ignored.
REQ-026 STATUS SHALL return 8'h00 repeatedly until CS rises.
REQ-027 JEDEC SHALL return JEDEC_ID[23:16], [15:8], [7:0], then 8'hFF repeatedly.
REQ-028 IGNORE SHALL keep o_MISO_OE low until CS rises.
REQ-029 o_MISO_OE SHALL assert on the falling edge that drives the first response bit and deassert when CS rises.
REQ-030 CS rising in any state SHALL force IDLE within 1 clk after synchronisation, deassert o_MISO_OE and o_BUSY, and abandon outstanding requests.
REQ-031 Data returned after a CS abort SHALL be discarded.
REQ-032 SCK edges while CS is high SHALL be ignored.

Reset
REQ-033 When reset is high at a clk edge, FSM SHALL go to IDLE, counters and shift registers to 0, and synchronisers to CS=1, SCK=0.
REQ-034 During reset, o_SPI_MISO, o_MISO_OE, o_RD_REQ, o_UNDERRUN and o_BUSY SHALL be 0, and o_RD_ADDR SHALL be 24'h000000.
REQ-035 Reset asserted mid-transfer SHALL abort it; the responder SHALL wait for a fresh CS falling edge.

Configuration
REQ-036 Macro SPI_FLASH_RESPONDER_JEDEC_EN defined SHALL enable opcode 0x9F and the JEDEC state.
REQ-037 Without SPI_FLASH_RESPONDER_JEDEC_EN, 0x9F SHALL be treated as unknown (IGNORE), and the JEDEC_ID parameter SHALL be unused.

Structure
REQ-038 Shared package spi_flash_pkg SHALL hold the opcode constants (0x03, 0x05, 0x9F), the FSM state encoding and the default JEDEC_ID.
REQ-039 One sub-module, spi_sync_edge, SHALL provide the synchroniser and rise/fall edge detection for SCK, with plain synchronisation of CS/MOSI.

Verification
REQ-040 The bench SHALL cover: READ 0x03 addr 0x00F000, data 0xA5 with 3-clk latency -> one o_RD_REQ at 0x00F000, MISO returns 0xA5, o_UNDERRUN=0.
REQ-041 The bench SHALL cover: READ 3 bytes from 0xFFFFFF -> requests at 0xFFFFFF, 0x000000, 0x000001, with data returned in order.
REQ-042 The bench SHALL cover: READ with i_RD_VALID withheld -> MISO byte 0xFF, one o_UNDERRUN pulse, next address still 0x00F001.
REQ-043 The bench SHALL cover: 0x9F with the macro -> EF 40 16 FF; without the macro -> o_MISO_OE stays 0.
REQ-044 The bench SHALL cover: CS raised after 12 address bits -> IDLE, no o_RD_REQ, o_BUSY=0, and the next 0x05 returns 0x00.
REQ-045 The bench SHALL cover: reset pulsed mid-DATA -> all outputs 0 the next clk, and a later transaction works.
